// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Holds the loader FSM state encoding, bytes-per-word and the count width.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT_HI,
        S_COUNT_LO,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned COUNT_W        = 16;

endpackage

// File: rtl/imem_loader_packer.sv
// byte_word_packer: shifts bytes MSB-first into a 32-bit word.
// Ports: clk, reset (async active-low), clear, shift_en, byte_in[7:0];
//        word[31:0], last_byte (next shift completes the word), word_full.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last_byte,
    output logic        word_full
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

    logic [31:0]      word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (shift_en) begin
            word_d = {word_q[23:0], byte_in};
            cnt_d  = cnt_q + CNT_W'(1);
            full_d = (cnt_q == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign word      = word_q;
    assign last_byte = (cnt_q == CNT_LAST);
    assign word_full = full_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a counted byte image into instruction memory and
// releases cpu_enable only after a complete (optionally checksummed) load.
// Ports: clk, reset (async active-low), start, rx_data/rx_valid/rx_ready,
//        imem_we/imem_addr/imem_wdata, cpu_enable, busy, done, err.
// Build option: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// 8-bit sum-of-data-bytes CHECK byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Capacity compared one bit wider so 2^ADDR_W itself is legal.
    localparam logic [COUNT_W:0] CAP = (COUNT_W+1)'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e S_LAST = S_CHECK;
`else
    localparam state_e S_LAST = S_DONE;
`endif

    state_e             state_q, state_d;
    logic [7:0]         cnt_hi_q, cnt_hi_d;
    logic [COUNT_W-1:0] left_q, left_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
`endif

    logic               accept;
    logic [COUNT_W-1:0] n_w;
    logic               pk_clear;
    logic               pk_shift;
    logic               pk_last;
    logic               pk_full;
    logic [31:0]        pk_word;

    assign rx_ready = (state_q == S_COUNT_HI) || (state_q == S_COUNT_LO)
                   || (state_q == S_DATA) || (state_q == S_CHECK);
    assign accept   = rx_valid & rx_ready;
    assign n_w      = {cnt_hi_q, rx_data};
    assign pk_shift = accept && (state_q == S_DATA);

    always_comb begin
        state_d  = state_q;
        cnt_hi_d = cnt_hi_q;
        left_d   = left_q;
        idx_d    = idx_q;
        pk_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d  = S_COUNT_HI;
                    left_d   = '0;
                    idx_d    = '0;
                    pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d    = '0;
`endif
                end
            end
            S_COUNT_HI: begin
                if (accept) begin
                    cnt_hi_d = rx_data;
                    state_d  = S_COUNT_LO;
                end
            end
            S_COUNT_LO: begin
                if (accept) begin
                    left_d = n_w;
                    if ({1'b0, n_w} > CAP)
                        state_d = S_ERROR;
                    else if (n_w == '0)
                        state_d = S_LAST;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + rx_data;
`endif
                    if (pk_last)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Packer is cleared as the word leaves; its value is
                // still on imem_wdata during this cycle.
                pk_clear = 1'b1;
                idx_d    = idx_q + ADDR_W'(1);
                left_d   = left_q - COUNT_W'(1);
                state_d  = (left_q == COUNT_W'(1)) ? S_LAST : S_DATA;
            end
            S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept)
                    state_d = (rx_data == sum_q) ? S_DONE : S_ERROR;
`else
                state_d = S_ERROR;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_hi_q <= '0;
            left_q   <= '0;
            idx_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_hi_q <= cnt_hi_d;
            left_q   <= left_d;
            idx_q    <= idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    byte_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pk_clear),
        .shift_en  (pk_shift),
        .byte_in   (rx_data),
        .word      (pk_word),
        .last_byte (pk_last),
        .word_full (pk_full)
    );

    assign imem_we    = (state_q == S_WRITE) & pk_full;
    assign imem_addr  = {{(30-ADDR_W){1'b0}}, idx_q, 2'b00};
    assign imem_wdata = pk_word;
    assign busy       = !((state_q == S_IDLE) || (state_q == S_DONE)
                       || (state_q == S_ERROR));
    assign done       = (state_q == S_DONE);
    assign cpu_enable = (state_q == S_DONE);
    assign err        = (state_q == S_ERROR);

endmodule
